// File: rtl/alu_pkg.sv
// Shared opcode, flag, instruction-field and state definitions for the ALU
// execute stage.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    localparam int INSTR_OP_LSB   = 6;
    localparam int INSTR_DST_LSB  = 4;
    localparam int INSTR_SRCA_LSB = 2;
    localparam int INSTR_SRCB_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Every instruction field is two bits wide.
    function automatic logic [1:0] instr_field(input logic [7:0] instr, input int lsb);
        return instr[lsb +: 2];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR with {N,Z,C} flags. For SUB, C is the borrow.
module alu
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   opcode,
    input  logic [W-1:0] operand_A,
    input  logic [W-1:0] operand_B,
    output logic [W-1:0] alu_result,
    output logic [2:0]   flags
);

    logic [W:0] wide;

    always_comb begin
        wide = '0;
        case (opcode)
            OP_ADD: wide = {1'b0, operand_A} + {1'b0, operand_B};
            OP_SUB: wide = {1'b0, operand_A} - {1'b0, operand_B};
            OP_AND: wide = {1'b0, operand_A & operand_B};
            OP_OR:  wide = {1'b0, operand_A | operand_B};
        endcase
        alu_result     = wide[W-1:0];
        flags          = '0;
        flags[FLAG_C]  = wide[W];
        flags[FLAG_Z]  = (wide[W-1:0] == '0);
        flags[FLAG_N]  = wide[W-1];
    end

endmodule

// File: rtl/alu_regfile.sv
// 4 x W register file: one write port shared by load and writeback, three
// combinational read ports (operand A, operand B, debug).
module alu_regfile #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_en_i,
    input  logic [1:0]   ld_addr_i,
    input  logic [W-1:0] ld_data_i,
    input  logic         wb_en_i,
    input  logic [1:0]   wb_addr_i,
    input  logic [W-1:0] wb_data_i,
    input  logic [1:0]   ra_addr_i,
    output logic [W-1:0] ra_data_o,
    input  logic [1:0]   rb_addr_i,
    output logic [W-1:0] rb_data_o,
    input  logic [1:0]   dbg_addr_i,
    output logic [W-1:0] dbg_data_o
);

    logic [W-1:0] rf_q [4];
    logic         we;
    logic [1:0]   waddr;
    logic [W-1:0] wdata;

    // Load and writeback are never requested together by the controller.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (wb_en_i) begin
            we    = 1'b1;
            waddr = wb_addr_i;
            wdata = wb_data_i;
        end else if (ld_en_i) begin
            we    = 1'b1;
            waddr = ld_addr_i;
            wdata = ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else if (we) begin
            rf_q[waddr] <= wdata;
        end
    end

    assign ra_data_o  = rf_q[ra_addr_i];
    assign rb_data_o  = rf_q[rb_addr_i];
    assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller around the combinational ALU: IDLE accepts loads
// or one instruction, EXEC writes back for one cycle, RESP holds the result.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_instr,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [1:0]   ld_addr,
    input  logic [W-1:0] ld_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [2:0]   out_flags,
    input  logic [1:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    state_t       state_q, state_d;
    logic [7:0]   ir_q, ir_d;
    logic [W-1:0] out_result_q, out_result_d;
    logic [2:0]   out_flags_q, out_flags_d;
    logic         out_valid_q, out_valid_d;
    logic         ld_en, wb_en;
    logic [W-1:0] op_a, op_b, alu_result;
    logic [2:0]   alu_flags;

    alu_regfile #(.W(W)) u_regfile (
        .clk        (clk),
        .rst_n      (reset_n),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (instr_field(ir_q, INSTR_DST_LSB)),
        .wb_data_i  (alu_result),
        .ra_addr_i  (instr_field(ir_q, INSTR_SRCA_LSB)),
        .ra_data_o  (op_a),
        .rb_addr_i  (instr_field(ir_q, INSTR_SRCB_LSB)),
        .rb_data_o  (op_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    alu #(.W(W)) u_alu (
        .opcode     (instr_field(ir_q, INSTR_OP_LSB)),
        .operand_A  (op_a),
        .operand_B  (op_b),
        .alu_result (alu_result),
        .flags      (alu_flags)
    );

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_valid_d  = out_valid_q;
        in_ready     = 1'b0;
        ld_ready     = 1'b0;
        ld_en        = 1'b0;
        wb_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A load in the same cycle wins; the instruction waits.
                ld_ready = 1'b1;
                in_ready = !ld_valid;
                ld_en    = ld_valid;
                if (in_valid && !ld_valid) begin
                    ir_d    = in_instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_en        = 1'b1;
                out_result_d = alu_result;
                out_flags_d  = alu_flags;
                out_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ir_q         <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: transaction-level model checked every
// negedge, plus hand-computed literal expectations for each scenario.
module tb_alu_exec_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_instr = '0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [1:0]   ld_addr = '0;
    logic [W-1:0] ld_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic [2:0]   out_flags;
    logic [1:0]   dbg_addr = '0;
    logic [W-1:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = accepting, 1 = instruction in flight, 2 = result offered.
    logic [W-1:0] m_rf [4];
    int           m_phase;
    logic [7:0]   m_ir;
    logic [W-1:0] m_res;
    logic [2:0]   m_flags;
    logic         m_valid;
    int           m_a, m_b, m_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_rf[i] = '0;
            m_phase = 0; m_ir = '0; m_res = '0; m_flags = '0; m_valid = 1'b0;
        end else if (m_phase == 0) begin
            if (ld_valid) m_rf[ld_addr] = ld_data;
            else if (in_valid) begin
                m_ir = in_instr;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_a = int'(m_rf[m_ir[3:2]]);
            m_b = int'(m_rf[m_ir[1:0]]);
            case (m_ir[7:6])
                2'd0:    m_r = m_a + m_b;
                2'd1:    m_r = m_a - m_b;
                2'd2:    m_r = m_a & m_b;
                default: m_r = m_a | m_b;
            endcase
            m_res   = m_r[W-1:0];
            m_flags = {m_res[W-1], m_res == '0, (m_r < 0) || (m_r > 255)};
            m_rf[m_ir[5:4]] = m_res;
            m_valid = 1'b1;
            m_phase = 2;
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, m_valid);
        check("in_ready", in_ready, (m_phase == 0) && !ld_valid);
        check("ld_ready", ld_ready, m_phase == 0);
        check("dbg_data", dbg_data, m_rf[dbg_addr]);
        check("out_result", out_result, m_res);
        check("out_flags", out_flags, m_flags);
    end

    task automatic do_load(input logic [1:0] a, input logic [W-1:0] d);
        @(negedge clk); #1;
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [W-1:0] exp, input string name);
        @(negedge clk); #2;
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    // Waits for out_valid, bounded; the first negedge after EXEC must see it.
    task automatic wait_result(input logic [W-1:0] exp_res, input logic [2:0] exp_fl, input string name);
        int n;
        for (n = 0; n < 8; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, " latency"}, n, 0);
        check({name, " result"}, out_result, exp_res);
        check({name, " flags"}, out_flags, exp_fl);
    endtask

    task automatic issue(input logic [7:0] instr, input logic [W-1:0] exp_res,
                         input logic [2:0] exp_fl, input string name);
        @(negedge clk); #1;
        in_valid = 1'b1; in_instr = instr;
        @(negedge clk); #1;
        in_valid = 1'b0;
        wait_result(exp_res, exp_fl, name);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst out_result", out_result, 0);
        check("rst out_flags", out_flags, 0);
        check("rst in_ready", in_ready, 1);
        #2 reset_n = 1'b1;

        // 1: asynchronous reset while a result is being held
        out_ready = 1'b0;
        do_load(2'd0, 8'd7);
        issue(8'b00_01_00_00, 8'd14, 3'b000, "t1 add");
        #2 reset_n = 1'b0;
        #1 check("t1 async out_valid", out_valid, 0);
        check("t1 async out_flags", out_flags, 0);
        @(negedge clk); #2;
        reset_n = 1'b1; out_ready = 1'b1;
        #1 check("t1 in_ready", in_ready, 1);
        for (int r = 0; r < 4; r++) chk_reg(r[1:0], 8'd0, "t1 rf clear");

        // 2: ADD and SUB with zero result
        do_load(2'd0, 8'd32);
        do_load(2'd1, 8'd32);
        issue(8'b00_10_00_01, 8'd64, 3'b000, "t2 add");
        chk_reg(2'd2, 8'd64, "t2 r2");
        issue(8'b01_11_00_01, 8'd0, 3'b010, "t2 sub");
        chk_reg(2'd3, 8'd0, "t2 r3");

        // 3: wrap with carry, destination aliases a source
        do_load(2'd0, 8'hFF);
        do_load(2'd1, 8'h01);
        issue(8'b00_00_00_01, 8'h00, 3'b011, "t3 add wrap");
        chk_reg(2'd0, 8'h00, "t3 r0");

        // 4: logic ops
        do_load(2'd0, 8'hAA);
        do_load(2'd1, 8'h55);
        issue(8'b10_10_00_01, 8'h00, 3'b010, "t4 and");
        issue(8'b11_11_00_01, 8'hFF, 3'b100, "t4 or");
        chk_reg(2'd3, 8'hFF, "t4 r3");

        // 5: back-pressure with ignored requests
        out_ready = 1'b0;
        issue(8'b00_10_00_01, 8'hFF, 3'b100, "t5 add");
        #1;
        in_valid = 1'b1; in_instr = 8'b01_00_00_00;
        ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 8'h11;
        repeat (5) begin
            @(negedge clk);
            check("t5 hold valid", out_valid, 1);
            check("t5 hold result", out_result, 8'hFF);
            check("t5 hold flags", out_flags, 3'b100);
            check("t5 in_ready", in_ready, 0);
            check("t5 ld_ready", ld_ready, 0);
        end
        #1;
        in_valid = 1'b0; ld_valid = 1'b0; out_ready = 1'b1;
        chk_reg(2'd0, 8'hAA, "t5 r0 kept");
        chk_reg(2'd1, 8'h55, "t5 r1 kept");

        // 6: load and instruction offered together
        do_load(2'd0, 8'd3);
        @(negedge clk); #1;
        ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'd5;
        in_valid = 1'b1; in_instr = 8'b00_10_00_01;
        #1 check("t6 in_ready blocked", in_ready, 0);
        @(negedge clk); #1;
        ld_valid = 1'b0;
        #1 check("t6 in_ready open", in_ready, 1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        wait_result(8'd8, 3'b000, "t6 add");
        chk_reg(2'd1, 8'd5, "t6 r1");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
